// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared constants, state type and byte parity helper for the 1RW+1R SRAM
package sram_pkg;

  localparam int BYTE_WIDTH     = 8;
  localparam int MAX_DATA_WIDTH = 1024;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Even parity per byte: the bit that makes the byte plus parity hold an even number of ones.
  function automatic logic [MAX_DATA_WIDTH/BYTE_WIDTH-1:0] byte_parity(
    input logic [MAX_DATA_WIDTH-1:0] data
  );
    logic [MAX_DATA_WIDTH/BYTE_WIDTH-1:0] par;
    for (int b = 0; b < MAX_DATA_WIDTH/BYTE_WIDTH; b++) begin
      par[b] = ^data[b*BYTE_WIDTH +: BYTE_WIDTH];
    end
    return par;
  endfunction

endpackage

// File: rtl/sram_init_seq.sv
// rtl/sram_init_seq.sv - power-on clear sequencer: walks every word once, then holds RUN until reset
module sram_init_seq
  import sram_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int RAM_DEPTH  = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  resetn,
  output logic                  ready,
  output logic                  init_we,
  output logic [ADDR_WIDTH-1:0] init_addr
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

  state_t                r_state;
  state_t                w_state_next;
  logic [ADDR_WIDTH-1:0] r_cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == INIT) begin
        r_cnt <= r_cnt + ADDR_WIDTH'(1);
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      INIT:    if (r_cnt == LAST_ADDR) w_state_next = RUN;
      RUN:     w_state_next = RUN;
      default: w_state_next = INIT;
    endcase
  end

  assign ready     = (r_state == RUN);
  assign init_we   = (r_state == INIT);
  assign init_addr = r_cnt;

endmodule

// File: rtl/sram_1rw1r_param.sv
// rtl/sram_1rw1r_param.sv - parametrised 1RW+1R SRAM with power-on clear, read valids and write-through
// Optional per-byte parity storage and checking under SRAM_PARITY_EN.
module sram_1rw1r_param
  import sram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int RAM_DEPTH  = 1 << ADDR_WIDTH,
  parameter int NUM_WMASKS = DATA_WIDTH / BYTE_WIDTH
) (
  input  logic                  clk,
  input  logic                  resetn,
  output logic                  ready,
  input  logic                  csb0,
  input  logic                  web0,
  input  logic [NUM_WMASKS-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] din0,
  output logic [DATA_WIDTH-1:0] dout0,
  output logic                  dout0_valid,
  input  logic                  csb1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic [DATA_WIDTH-1:0] dout1,
  output logic                  dout1_valid,
  output logic                  collision,
  input  logic                  perr_inject,
  output logic                  perr0,
  output logic                  perr1
);

  logic [DATA_WIDTH-1:0] r_mem [RAM_DEPTH];

  logic                  w_init_we;
  logic [ADDR_WIDTH-1:0] w_init_addr;
  logic                  w_in0, w_in1;
  logic                  w_wr, w_rd0, w_rd1, w_coll;
  logic [DATA_WIDTH-1:0] w_rd0_data, w_rd1_old, w_rd1_data;

  sram_init_seq #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .RAM_DEPTH  (RAM_DEPTH)
  ) u_init_seq (
    .clk       (clk),
    .resetn    (resetn),
    .ready     (ready),
    .init_we   (w_init_we),
    .init_addr (w_init_addr)
  );

  assign w_in0  = int'(addr0) < RAM_DEPTH;
  assign w_in1  = int'(addr1) < RAM_DEPTH;
  assign w_wr   = ready & ~csb0 & ~web0 & w_in0;
  assign w_rd0  = ready & ~csb0 & web0;
  assign w_rd1  = ready & ~csb1;
  assign w_coll = w_wr & w_rd1 & (addr0 == addr1);

  assign w_rd0_data = w_in0 ? r_mem[addr0] : '0;
  assign w_rd1_old  = w_in1 ? r_mem[addr1] : '0;

  // Port 1 sees the bytes port 0 is writing on the same edge; the rest come from the array.
  always_comb begin
    w_rd1_data = w_rd1_old;
    if (w_coll) begin
      for (int b = 0; b < NUM_WMASKS; b++) begin
        if (wmask0[b]) w_rd1_data[b*BYTE_WIDTH +: BYTE_WIDTH] = din0[b*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_init_we) begin
      r_mem[w_init_addr] <= '0;
    end else if (w_wr) begin
      for (int b = 0; b < NUM_WMASKS; b++) begin
        if (wmask0[b]) r_mem[addr0][b*BYTE_WIDTH +: BYTE_WIDTH] <= din0[b*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dout0       <= '0;
      dout0_valid <= 1'b0;
      dout1       <= '0;
      dout1_valid <= 1'b0;
      collision   <= 1'b0;
    end else begin
      dout0_valid <= w_rd0;
      dout1_valid <= w_rd1;
      collision   <= w_coll;
      if (w_rd0) dout0 <= w_rd0_data;
      if (w_rd1) dout1 <= w_rd1_data;
    end
  end

`ifdef SRAM_PARITY_EN
  logic [NUM_WMASKS-1:0] r_par [RAM_DEPTH];
  logic [NUM_WMASKS-1:0] w_din_par, w_par0, w_par1;
  logic                  r_perr0, r_perr1;

  function automatic logic [NUM_WMASKS-1:0] word_parity(input logic [DATA_WIDTH-1:0] d);
    logic [MAX_DATA_WIDTH-1:0]            ext;
    logic [MAX_DATA_WIDTH/BYTE_WIDTH-1:0] p;
    ext                 = '0;
    ext[DATA_WIDTH-1:0] = d;
    p                   = byte_parity(ext);
    return p[NUM_WMASKS-1:0];
  endfunction

  assign w_din_par = word_parity(din0);
  assign w_par0    = w_in0 ? r_par[addr0] : '0;

  always_comb begin
    w_par1 = w_in1 ? r_par[addr1] : '0;
    if (w_coll) begin
      for (int b = 0; b < NUM_WMASKS; b++) begin
        if (wmask0[b]) w_par1[b] = w_din_par[b];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_init_we) begin
      r_par[w_init_addr] <= '0;
    end else if (w_wr) begin
      for (int b = 0; b < NUM_WMASKS; b++) begin
        if (wmask0[b]) r_par[addr0][b] <= w_din_par[b] ^ perr_inject;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_perr0 <= 1'b0;
      r_perr1 <= 1'b0;
    end else begin
      r_perr0 <= w_rd0 & (|(word_parity(w_rd0_data) ^ w_par0));
      r_perr1 <= w_rd1 & (|(word_parity(w_rd1_data) ^ w_par1));
    end
  end

  assign perr0 = r_perr0;
  assign perr1 = r_perr1;
`else
  logic w_unused_perr_inject;
  assign w_unused_perr_inject = perr_inject;
  assign perr0 = 1'b0;
  assign perr1 = 1'b0;
`endif

endmodule

// File: tb/tb_sram_1rw1r_param.sv
// tb/tb_sram_1rw1r_param.sv - self-checking bench: full-depth and reduced-depth SRAMs on shared stimulus
module tb_sram_1rw1r_param;

  localparam int DEP_A = 256;
  localparam int DEP_B = 200;
`ifdef SRAM_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn;
  logic        csb0, web0, csb1, perr_inject;
  logic [3:0]  wmask0;
  logic [7:0]  addr0, addr1;
  logic [31:0] din0;

  logic [1:0]       rdy, v0, v1, col, pe0, pe1;
  logic [1:0][31:0] d0, d1;

  always #5 clk = ~clk;

  sram_1rw1r_param u_dut_a (
    .clk(clk), .resetn(resetn), .ready(rdy[0]),
    .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0), .din0(din0),
    .dout0(d0[0]), .dout0_valid(v0[0]),
    .csb1(csb1), .addr1(addr1), .dout1(d1[0]), .dout1_valid(v1[0]),
    .collision(col[0]), .perr_inject(perr_inject), .perr0(pe0[0]), .perr1(pe1[0])
  );

  sram_1rw1r_param #(.RAM_DEPTH(DEP_B)) u_dut_b (
    .clk(clk), .resetn(resetn), .ready(rdy[1]),
    .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0), .din0(din0),
    .dout0(d0[1]), .dout0_valid(v0[1]),
    .csb1(csb1), .addr1(addr1), .dout1(d1[1]), .dout1_valid(v1[1]),
    .collision(col[1]), .perr_inject(perr_inject), .perr0(pe0[1]), .perr1(pe1[1])
  );

  // Reference model: word contents plus a per-byte "stored with corrupted parity" flag.
  logic [31:0] mm [2][256];
  logic [3:0]  mc [2][256];
  int          edges;
  logic [31:0] e_d0 [2];
  logic [31:0] e_d1 [2];
  bit          e_v0 [2];
  bit          e_v1 [2];
  bit          e_col [2];
  bit          e_p0 [2];
  bit          e_p1 [2];

  int n_chk;
  int n_fail;

  typedef struct {
    logic        c0, w0;
    logic [3:0]  m0;
    logic [7:0]  a0;
    logic [31:0] dd0;
    logic        c1;
    logic [7:0]  a1;
    logic        ev0;
    logic [31:0] ed0;
    logic        ev1;
    logic [31:0] ed1;
    logic        ecol;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int a = 0; a < 256; a++) begin
        mm[d][a] = '0;
        mc[d][a] = '0;
      end
      e_d0[d] = '0; e_d1[d] = '0;
      e_v0[d] = 0; e_v1[d] = 0; e_col[d] = 0; e_p0[d] = 0; e_p1[d] = 0;
    end
    edges = 0;
  endtask

  task automatic check_all(input string tag);
    string nm;
    int    dep;
    for (int d = 0; d < 2; d++) begin
      nm  = (d == 0) ? {tag, ".a"} : {tag, ".b"};
      dep = (d == 0) ? DEP_A : DEP_B;
      chk({nm, ".ready"},       32'(rdy[d]), 32'(edges >= dep));
      chk({nm, ".dout0"},       d0[d],       e_d0[d]);
      chk({nm, ".dout0_valid"}, 32'(v0[d]),  32'(e_v0[d]));
      chk({nm, ".dout1"},       d1[d],       e_d1[d]);
      chk({nm, ".dout1_valid"}, 32'(v1[d]),  32'(e_v1[d]));
      chk({nm, ".collision"},   32'(col[d]), 32'(e_col[d]));
      chk({nm, ".perr0"},       32'(pe0[d]), 32'(e_p0[d]));
      chk({nm, ".perr1"},       32'(pe1[d]), 32'(e_p1[d]));
    end
  endtask

  task automatic step(input string tag);
    int         dep;
    bit         in0, in1;
    logic [3:0] cold;
    for (int d = 0; d < 2; d++) begin
      dep = (d == 0) ? DEP_A : DEP_B;
      e_v0[d] = 0; e_v1[d] = 0; e_col[d] = 0; e_p0[d] = 0; e_p1[d] = 0;
      if (edges >= dep) begin
        in0 = int'(addr0) < dep;
        in1 = int'(addr1) < dep;
        if (!csb0 && web0) begin
          e_v0[d] = 1;
          e_d0[d] = in0 ? mm[d][addr0] : 32'h0;
          e_p0[d] = in0 && (mc[d][addr0] != 4'h0);
        end
        if (!csb1) begin
          e_v1[d] = 1;
          e_d1[d] = in1 ? mm[d][addr1] : 32'h0;
          e_p1[d] = in1 && (mc[d][addr1] != 4'h0);
        end
        if (!csb0 && !web0 && in0) begin
          cold = mc[d][addr0];
          for (int b = 0; b < 4; b++) begin
            if (wmask0[b]) begin
              mm[d][addr0][8*b +: 8] = din0[8*b +: 8];
              mc[d][addr0][b]        = PAR & perr_inject;
            end
          end
          if (!csb1 && addr1 == addr0) begin
            e_col[d] = 1;
            e_d1[d]  = mm[d][addr0];
            e_p1[d]  = (cold & ~wmask0) != 4'h0;
          end
        end
      end
    end
    @(posedge clk);
    #1;
    edges++;
    check_all(tag);
  endtask

  task automatic set_in(input logic c0, input logic w0, input logic [3:0] m0, input logic [7:0] a0,
                        input logic [31:0] dd0, input logic c1, input logic [7:0] a1, input logic inj);
    csb0 = c0; web0 = w0; wmask0 = m0; addr0 = a0; din0 = dd0;
    csb1 = c1; addr1 = a1; perr_inject = inj;
  endtask

  function automatic logic [7:0] pick();
    int r;
    r = $urandom_range(0, 15);
    if (r < 7) return 8'(r);
    if (r == 7) return 8'hC7;
    return 8'(8'hC0 + r);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, nb;
    n_chk  = 0;
    n_fail = 0;

    tbl[0]  = '{1'b0, 1'b1, 4'h0, 8'h00, 32'h0,        1'b0, 8'hFF, 1'b1, 32'h0,        1'b1, 32'h0,        1'b0};
    tbl[1]  = '{1'b0, 1'b1, 4'h0, 8'h05, 32'h0,        1'b1, 8'h00, 1'b1, 32'h0,        1'b0, 32'h0,        1'b0};
    tbl[2]  = '{1'b0, 1'b0, 4'hF, 8'h10, 32'hDEADBEEF, 1'b1, 8'h00, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0};
    tbl[3]  = '{1'b0, 1'b0, 4'h5, 8'h10, 32'h11223344, 1'b1, 8'h00, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0};
    tbl[4]  = '{1'b0, 1'b1, 4'h0, 8'h10, 32'h0,        1'b1, 8'h00, 1'b1, 32'hDE22BE44, 1'b0, 32'h0,        1'b0};
    tbl[5]  = '{1'b0, 1'b0, 4'hF, 8'h20, 32'h12345678, 1'b1, 8'h00, 1'b0, 32'hDE22BE44, 1'b0, 32'h0,        1'b0};
    tbl[6]  = '{1'b0, 1'b0, 4'h3, 8'h20, 32'hAABBCCDD, 1'b0, 8'h20, 1'b0, 32'hDE22BE44, 1'b1, 32'h1234CCDD, 1'b1};
    tbl[7]  = '{1'b0, 1'b1, 4'h0, 8'h20, 32'h0,        1'b0, 8'h20, 1'b1, 32'h1234CCDD, 1'b1, 32'h1234CCDD, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 4'h0, 8'h10, 32'hFFFFFFFF, 1'b1, 8'h00, 1'b0, 32'h1234CCDD, 1'b0, 32'h1234CCDD, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 4'h0, 8'h10, 32'h0,        1'b0, 8'h10, 1'b1, 32'hDE22BE44, 1'b1, 32'hDE22BE44, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 4'h0, 8'h00, 32'h0,        1'b1, 8'h00, 1'b0, 32'hDE22BE44, 1'b0, 32'hDE22BE44, 1'b0};

    resetn = 1'b0;
    set_in(1, 1, 4'h0, 8'h00, 32'h0, 1, 8'h00, 0);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all("reset");
    resetn = 1'b1;

    // Port requests during the clear must be ignored.
    set_in(0, 0, 4'hF, 8'h05, 32'hFFFFFFFF, 0, 8'h05, 0);
    n  = 0;
    nb = 0;
    while (!rdy[0] && n < 400) begin
      step("init");
      n++;
      if (rdy[1] && nb == 0) nb = n;
    end
    chk("ready_edges.a", n, DEP_A);
    chk("ready_edges.b", nb, DEP_B);

    for (int i = 0; i < 11; i++) begin
      set_in(tbl[i].c0, tbl[i].w0, tbl[i].m0, tbl[i].a0, tbl[i].dd0, tbl[i].c1, tbl[i].a1, 0);
      step($sformatf("vec%0d", i));
      chk($sformatf("vec%0d.dout0_valid", i), 32'(v0[0]), 32'(tbl[i].ev0));
      chk($sformatf("vec%0d.dout0", i), d0[0], tbl[i].ed0);
      chk($sformatf("vec%0d.dout1_valid", i), 32'(v1[0]), 32'(tbl[i].ev1));
      chk($sformatf("vec%0d.dout1", i), d1[0], tbl[i].ed1);
      chk($sformatf("vec%0d.collision", i), 32'(col[0]), 32'(tbl[i].ecol));
    end

    // 0xC8 is past the end of the 200-word instance but inside the full one.
    set_in(0, 0, 4'hF, 8'hC8, 32'h55AA55AA, 0, 8'hC8, 0);
    step("oor_wr");
    chk("oor.a.collision", 32'(col[0]), 32'h1);
    chk("oor.a.dout1", d1[0], 32'h55AA55AA);
    chk("oor.b.collision", 32'(col[1]), 32'h0);
    chk("oor.b.dout1", d1[1], 32'h0);
    chk("oor.b.dout1_valid", 32'(v1[1]), 32'h1);
    set_in(0, 1, 4'h0, 8'hC8, 32'h0, 1, 8'h00, 0);
    step("oor_rd");
    chk("oor.b.dout0", d0[1], 32'h0);
    chk("oor.b.dout0_valid", 32'(v0[1]), 32'h1);
    chk("oor.a.dout0", d0[0], 32'h55AA55AA);
    set_in(0, 0, 4'hF, 8'hC7, 32'h0BADCAFE, 1, 8'h00, 0);
    step("last_wr");
    set_in(0, 1, 4'h0, 8'hC7, 32'h0, 1, 8'h00, 0);
    step("last_rd");
    chk("last.b.dout0", d0[1], 32'h0BADCAFE);

    // Parity corruption is only observable when parity storage is built in.
    set_in(0, 0, 4'hF, 8'h40, 32'h000000FF, 1, 8'h00, 1);
    step("par_inj_wr");
    set_in(1, 1, 4'h0, 8'h00, 32'h0, 0, 8'h40, 0);
    step("par_inj_rd");
    chk("par.inject.perr1", 32'(pe1[0]), 32'(PAR));
    chk("par.inject.dout1_valid", 32'(v1[0]), 32'h1);
    set_in(0, 0, 4'hF, 8'h40, 32'h000000FF, 1, 8'h00, 0);
    step("par_clean_wr");
    set_in(1, 1, 4'h0, 8'h00, 32'h0, 0, 8'h40, 0);
    step("par_clean_rd");
    chk("par.clean.perr1", 32'(pe1[0]), 32'h0);

    // Reset in the middle of traffic, with outputs holding non-zero data.
    set_in(0, 0, 4'hF, 8'h30, 32'hCAFEF00D, 1, 8'h00, 0);
    step("mid_wr");
    set_in(0, 1, 4'h0, 8'h30, 32'h0, 0, 8'h30, 0);
    step("mid_rd");
    chk("mid.dout0", d0[0], 32'hCAFEF00D);
    resetn = 1'b0;
    #1;
    model_reset();
    check_all("midrst");
    set_in(1, 1, 4'h0, 8'h00, 32'h0, 1, 8'h00, 0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    n = 0;
    while (!rdy[0] && n < 400) begin
      step("reinit");
      n++;
    end
    chk("reready_edges.a", n, DEP_A);
    set_in(0, 1, 4'h0, 8'h30, 32'h0, 1, 8'h00, 0);
    step("mid_after");
    chk("mid.after.dout0", d0[0], 32'h0);
    chk("mid.after.dout0_valid", 32'(v0[0]), 32'h1);

    for (int i = 0; i < 800; i++) begin
      csb0        = ($urandom_range(0, 3) == 0);
      web0        = 1'($urandom_range(0, 1));
      wmask0      = 4'($urandom);
      addr0       = pick();
      din0        = $urandom;
      csb1        = ($urandom_range(0, 3) == 0);
      addr1       = ($urandom_range(0, 2) == 0) ? addr0 : pick();
      perr_inject = ($urandom_range(0, 7) == 0);
      step("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_1rw1r_param.md
Name: sram_1rw1r_param

Overview:
- Parametrised single-clock 1RW+1R SRAM behavioural model for user-project RAM macros.
- Next generation of the fixed 32x256 OpenRAM model. Adds:
  - generic width, depth and byte-mask width;
  - power-on memory clear sequencer with a ready flag;
  - deterministic read latency with valid strobes;
  - defined write-through on same-address port collision.
- Sits behind the wishbone/logic-analyser glue in the user area, wherever a clean-initialised scratch RAM is needed.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 8, address width in bits.
- RAM_DEPTH, 1<<ADDR_WIDTH, number of implemented words; must be ≤ 2^ADDR_WIDTH.
- NUM_WMASKS, DATA_WIDTH/8, write-mask bits, one per byte.

Ports:
- clk  in  1  single clock for both ports.
- resetn  in  1  asynchronous active-low reset.
- ready  out  1  high once the memory clear is complete.
- csb0  in  1  port 0 active-low chip select.
- web0  in  1  port 0 active-low write enable.
- wmask0  in  NUM_WMASKS  port 0 byte write mask.
- addr0  in  ADDR_WIDTH  port 0 address.
- din0  in  DATA_WIDTH  port 0 write data.
- dout0  out  DATA_WIDTH  port 0 read data.
- dout0_valid  out  1  port 0 read-data strobe.
- csb1  in  1  port 1 active-low chip select (read only).
- addr1  in  ADDR_WIDTH  port 1 address.
- dout1  out  DATA_WIDTH  port 1 read data.
- dout1_valid  out  1  port 1 read-data strobe.
- collision  out  1  port 1 read hit a same-cycle port 0 write.
- perr_inject  in  1  test input: invert stored parity of bytes written this cycle.
- perr0  out  1  port 0 parity error, qualified by dout0_valid.
- perr1  out  1  port 1 parity error, qualified by dout1_valid.

Behaviour:
- One clock, clk; reset is asynchronous and active-low on resetn.
- Reset values: all outputs 0 (ready, dout0, dout0_valid, dout1, dout1_valid, collision, perr0, perr1); clear counter 0; state INIT.
- State machine: INIT -> RUN; there is no path back except resetn.
- INIT state:
  - Each rising edge writes all-zero to mem[cnt] and increments cnt.
  - After the edge that clears RAM_DEPTH-1: ready=1 and state becomes RUN. ready therefore rises after exactly RAM_DEPTH edges following reset release.
  - csb0 and csb1 are ignored, so no port activity and valids stay 0.
- RUN, port 0:
  - Inputs are sampled at rising edge k.
  - Write (csb0=0, web0=0): byte b is written only if wmask0[b]=1. wmask0=0 is a legal no-op.
  - Read (csb0=0, web0=1): dout0 takes mem[addr0] at edge k; dout0_valid=1 for the cycle after edge k. Read latency is 1 cycle.
- RUN, port 1: read with the same timing on dout1 and dout1_valid.
- Outputs hold their last value when no read occurs; valids are single-cycle pulses.
- Collision: port 0 write and port 1 read to the same in-range address at the same edge.
  - dout1 returns the new data for masked bytes and the old data for unmasked bytes (write-through).
  - collision=1 for one cycle, aligned with dout1_valid.
- Out-of-range address (≥ RAM_DEPTH):
  - writes are dropped;
  - reads return 0 with the valid still asserted;
  - no collision is flagged.
- Port 0 read and port 1 read of the same address are both legal and return identical data.
- resetn asserted mid-operation: immediate return to INIT; all outputs go to their reset values; memory is cleared again after release.

Optional Feature:
- Macro: SRAM_PARITY_EN.
- Defined:
  - Each byte stores an even-parity bit, computed on write (including INIT zeros) and inverted when perr_inject=1.
  - On read, perr0/perr1 = 1 when any byte's recomputed parity mismatches. They assert with the valid, and are 0 otherwise.
  - Collision-forwarded bytes use the parity of the new data.
- Undefined: no parity storage; perr0=perr1=0 constantly; perr_inject is ignored; the ports remain present.

Decomposition:
- Shared package sram_pkg holds:
  - BYTE_WIDTH=8 constant;
  - state type {INIT, RUN};
  - function byte_parity(data) returning one bit per byte.
- One natural sub-module: sram_init_seq, holding the clear counter and state register and producing ready, init_we and init_addr.

Test Plan:
- Default params: release resetn, count edges -> ready rises after edge 256; a read of addr 0x00 and of addr 0xFF returns 0x00000000 with dout_valid=1.
- Write 0xDEADBEEF to 0x10 with wmask0=4'b1111, then write 0x11223344 with wmask0=4'b0101 -> port 0 read of 0x10 returns 0xDE22BE44 one cycle after the request.
- Same edge: port 0 write 0xAABBCCDD with wmask 4'b0011 to 0x20 (old value 0x12345678) and port 1 read of 0x20 -> dout1=0x1234CCDD; collision=1 for one cycle; a later read returns 0x1234CCDD.
- Requests during INIT (csb0=0, web0=0, addr 0x05, din 0xFFFFFFFF) -> ignored; 0x05 reads 0 after ready.
- Assert resetn mid-stream after writing 0xCAFEF00D to 0x30 -> outputs go to 0 immediately; after ready re-rises, 0x30 reads 0.
- SRAM_PARITY_EN: write 0x000000FF to 0x40 with perr_inject=1 -> read gives perr1=1 with dout1_valid. A normal rewrite of the same word -> perr1=0.
